// File: rtl/btn_debouncer_pkg.sv
// Shared types and default timings for the push-button debouncer.
package btn_debouncer_pkg;

    // IDLE         | button released and stable
    // PRESS_WAIT   | synchronised input low, counting stable samples
    // PRESSED      | press accepted, btn_n_out held low
    // RELEASE_WAIT | synchronised input high, counting stable samples
    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } debounce_state_t;

    // 10 ms at 50 MHz
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 500000;
    // 500 ms before the first auto-repeat, then one every 200 ms
    localparam int unsigned DEF_REPEAT_DELAY    = 25000000;
    localparam int unsigned DEF_REPEAT_PERIOD   = 10000000;

endpackage

// File: rtl/btn_debouncer_sync.sv
// Two-flop synchroniser for asynchronous inputs; resets to all ones
// so an active-low button reads as released.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // Double-register the asynchronous input into the clk domain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= '1;
            q    <= '1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/btn_debouncer.sv
// Debouncer for one active-low push-button: 2-FF synchroniser, stability
// counter and press/release FSM with registered one-cycle strobes.
// Optional build macro BTN_DEBOUNCER_AUTO_REPEAT_EN adds press_pulse
// auto-repeat while the button is held.
module btn_debouncer
    import btn_debouncer_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES + 1),
    parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_n_in,
    output logic btn_n_out,
    output logic press_pulse,
    output logic release_pulse
);

    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("btn_debouncer: DEBOUNCE_CYCLES must be >= 2");
    end
    if (REPEAT_PERIOD < 1 || REPEAT_PERIOD > REPEAT_DELAY) begin : g_bad_repeat
        $error("btn_debouncer: need 1 <= REPEAT_PERIOD <= REPEAT_DELAY");
    end

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    debounce_state_t  state;
    logic [CNT_W-1:0] cnt;
    logic             s;
    logic             rpt_hit;

    sync_2ff #(.WIDTH(1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (btn_n_in),
        .q   (s)
    );

`ifdef BTN_DEBOUNCER_AUTO_REPEAT_EN
    localparam int unsigned RPT_W = $clog2(REPEAT_DELAY + 1);
    localparam logic [RPT_W-1:0] RPT_LAST   = RPT_W'(REPEAT_DELAY - 1);
    // Reloading to DELAY-PERIOD makes later hits land every REPEAT_PERIOD cycles
    localparam logic [RPT_W-1:0] RPT_RELOAD = RPT_W'(REPEAT_DELAY - REPEAT_PERIOD);

    logic [RPT_W-1:0] rpt_cnt;

    assign rpt_hit = (state == PRESSED) && !s && (rpt_cnt == RPT_LAST);

    // Cycles since acceptance while held; cleared whenever not PRESSED
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rpt_cnt <= '0;
        end else if (state != PRESSED) begin
            rpt_cnt <= '0;
        end else if (rpt_hit) begin
            rpt_cnt <= RPT_RELOAD;
        end else begin
            rpt_cnt <= rpt_cnt + RPT_W'(1);
        end
    end
`else
    assign rpt_hit = 1'b0;
`endif

    // Press/release FSM; the stability counter never passes CNT_LAST
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            btn_n_out     <= 1'b1;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (!s) begin
                        state <= PRESS_WAIT;
                        cnt   <= CNT_W'(1);
                    end else begin
                        cnt   <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (s) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state       <= PRESSED;
                        btn_n_out   <= 1'b0;
                        press_pulse <= 1'b1;
                        cnt         <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                PRESSED: begin
                    if (s) begin
                        state <= RELEASE_WAIT;
                        cnt   <= CNT_W'(1);
                    end else begin
                        press_pulse <= rpt_hit;
                    end
                end
                RELEASE_WAIT: begin
                    if (!s) begin
                        state <= PRESSED;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state         <= IDLE;
                        btn_n_out     <= 1'b1;
                        release_pulse <= 1'b1;
                        cnt           <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule
